// File: rtl/sys_ctrl_frame_pkg.sv
// Shared definitions for the command-frame controller: opcodes, FSM states
// and the default error byte.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR       = 8'hAA;
  localparam logic [7:0] CMD_RD       = 8'hBB;
  localparam logic [7:0] CMD_ALU      = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] CMD_BURST    = 8'hEE;
  localparam logic [7:0] DEF_ERR_CODE = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_RD_CNT   = 4'd4,
    ST_RD_REQ   = 4'd5,
    ST_RD_SEND  = 4'd6,
    ST_OPA      = 4'd7,
    ST_OPB      = 4'd8,
    ST_FUNC     = 4'd9,
    ST_ALU_RUN  = 4'd10,
    ST_ALU_SEND = 4'd11,
    ST_ERR_SEND = 4'd12
  } state_e;

endpackage

// File: rtl/sys_ctrl_frame_if.sv
// Bus bundle between the frame controller (master) and the UART RX, register
// file, ALU and TX FIFO (slave side).
interface sys_ctrl_frame_if #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int FUNC_W    = 4,
  parameter int ALU_OUT_W = 16
);
  logic [DATA_W-1:0]    rx_data;
  logic                 rx_valid;
  logic [ALU_OUT_W-1:0] alu_out;
  logic                 alu_valid;
  logic [DATA_W-1:0]    rd_data;
  logic                 rd_valid;
  logic                 fifo_full;
  logic                 alu_en;
  logic [FUNC_W-1:0]    alu_func;
  logic                 alu_clk_en;
  logic [ADDR_W-1:0]    addr;
  logic                 wr_en;
  logic                 rd_en;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W-1:0]    tx_data;
  logic                 tx_push;
  logic                 clk_div_en;
  logic                 frame_err;

  modport master (
    input  rx_data, rx_valid, alu_out, alu_valid, rd_data, rd_valid, fifo_full,
    output alu_en, alu_func, alu_clk_en, addr, wr_en, rd_en, wr_data,
           tx_data, tx_push, clk_div_en, frame_err
  );

  modport slave (
    output rx_data, rx_valid, alu_out, alu_valid, rd_data, rd_valid, fifo_full,
    input  alu_en, alu_func, alu_clk_en, addr, wr_en, rd_en, wr_data,
           tx_data, tx_push, clk_div_en, frame_err
  );
endinterface

// File: rtl/sys_ctrl_frame_timer.sv
// Inter-byte timeout counter: cleared by clr, advances while en, saturates at
// TIMEOUT and flags hit there. TIMEOUT of 0 disables the hit.
module frame_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count_r;

  // saturating idle-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en && (count_r != LIMIT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (TIMEOUT != 0) && en && !clr && (count_r == LIMIT);

endmodule

// File: rtl/sys_ctrl_frame.sv
// Command-frame controller: decodes framed UART commands into register-file
// and ALU strobes and pushes results to the TX FIFO.
module sys_ctrl_frame
  import sys_ctrl_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 4,
  parameter int                FUNC_W    = 4,
  parameter int                ALU_OUT_W = 16,
  parameter int                TIMEOUT   = 1023,
  parameter logic [ADDR_W-1:0] OPA_ADDR  = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] OPB_ADDR  = ADDR_W'(1),
  parameter logic [DATA_W-1:0] ERR_CODE  = DATA_W'(DEF_ERR_CODE)
) (
  input logic               clk,
  input logic               rst,
  sys_ctrl_frame_if.master  bus
);
  localparam int NBYTES = ALU_OUT_W / DATA_W;
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  state_e               state_r, state_nx;
  logic [ADDR_W-1:0]    addr_r, addr_nx;
  logic [DATA_W-1:0]    cnt_r, cnt_nx;
  logic [FUNC_W-1:0]    func_r, func_nx;
  logic [DATA_W-1:0]    tx_r, tx_nx;
  logic [ALU_OUT_W-1:0] res_r, res_nx;
  logic [IW-1:0]        idx_r, idx_nx;
  logic                 burst_r, burst_nx;
  logic                 timer_en_s, timer_hit_s;
  logic [ALU_OUT_W-1:0] res_shift_s;

  assign timer_en_s = (state_r == ST_WR_ADDR) || (state_r == ST_WR_DATA) ||
                      (state_r == ST_RD_ADDR) || (state_r == ST_RD_CNT)  ||
                      (state_r == ST_OPA)     || (state_r == ST_OPB)     ||
                      (state_r == ST_FUNC);
  assign res_shift_s = res_r >> (DATA_W * int'(idx_r));
  assign bus.clk_div_en = 1'b1;

  frame_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (bus.rx_valid),
    .en  (timer_en_s),
    .hit (timer_hit_s)
  );

  // state and frame context registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      addr_r  <= '0;
      cnt_r   <= '0;
      func_r  <= '0;
      tx_r    <= '0;
      res_r   <= '0;
      idx_r   <= '0;
      burst_r <= 1'b0;
    end else begin
      state_r <= state_nx;
      addr_r  <= addr_nx;
      cnt_r   <= cnt_nx;
      func_r  <= func_nx;
      tx_r    <= tx_nx;
      res_r   <= res_nx;
      idx_r   <= idx_nx;
      burst_r <= burst_nx;
    end
  end

  // next-state and context update
  always_comb begin
    state_nx = state_r;
    addr_nx  = addr_r;
    cnt_nx   = cnt_r;
    func_nx  = func_r;
    tx_nx    = tx_r;
    res_nx   = res_r;
    idx_nx   = idx_r;
    burst_nx = burst_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            DATA_W'(CMD_WR):      state_nx = ST_WR_ADDR;
            DATA_W'(CMD_RD):      begin state_nx = ST_RD_ADDR; burst_nx = 1'b0; end
            DATA_W'(CMD_BURST):   begin state_nx = ST_RD_ADDR; burst_nx = 1'b1; end
            DATA_W'(CMD_ALU):     state_nx = ST_OPA;
            DATA_W'(CMD_ALU_NOP): state_nx = ST_FUNC;
            default:              state_nx = ST_ERR_SEND;
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_WR_ADDR: begin
        if (bus.rx_valid) begin
          addr_nx  = bus.rx_data[ADDR_W-1:0];
          state_nx = ST_WR_DATA;
        end else if (timer_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_WR_ADDR;
        end
      end
      ST_WR_DATA, ST_OPA, ST_OPB: begin
        if (bus.rx_valid) begin
          state_nx = (state_r == ST_WR_DATA) ? ST_IDLE :
                     (state_r == ST_OPA)     ? ST_OPB  : ST_FUNC;
        end else if (timer_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = state_r;
        end
      end
      ST_RD_ADDR: begin
        if (bus.rx_valid) begin
          addr_nx  = bus.rx_data[ADDR_W-1:0];
          cnt_nx   = burst_r ? cnt_r : DATA_W'(1);
          state_nx = burst_r ? ST_RD_CNT : ST_RD_REQ;
        end else if (timer_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RD_ADDR;
        end
      end
      ST_RD_CNT: begin
        if (bus.rx_valid) begin
          cnt_nx   = bus.rx_data;
          state_nx = (bus.rx_data == '0) ? ST_ERR_SEND : ST_RD_REQ;
        end else if (timer_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RD_CNT;
        end
      end
      ST_RD_REQ: begin
        if (bus.rd_valid) begin
          tx_nx    = bus.rd_data;
          state_nx = ST_RD_SEND;
        end else begin
          state_nx = ST_RD_REQ;
        end
      end
      ST_RD_SEND: begin
        if (!bus.fifo_full) begin
          cnt_nx   = cnt_r - DATA_W'(1);
          addr_nx  = addr_r + ADDR_W'(1);
          state_nx = (cnt_r != DATA_W'(1)) ? ST_RD_REQ : ST_IDLE;
        end else begin
          state_nx = ST_RD_SEND;
        end
      end
      ST_FUNC: begin
        if (bus.rx_valid) begin
          func_nx  = bus.rx_data[FUNC_W-1:0];
          state_nx = ST_ALU_RUN;
        end else if (timer_hit_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_FUNC;
        end
      end
      ST_ALU_RUN: begin
        if (bus.alu_valid) begin
          res_nx   = bus.alu_out;
          idx_nx   = '0;
          state_nx = ST_ALU_SEND;
        end else begin
          state_nx = ST_ALU_RUN;
        end
      end
      ST_ALU_SEND: begin
        if (!bus.fifo_full) begin
          if (idx_r == IW'(NBYTES - 1)) begin
            state_nx = ST_IDLE;
          end else begin
            idx_nx = idx_r + IW'(1);
          end
        end else begin
          state_nx = ST_ALU_SEND;
        end
      end
      ST_ERR_SEND: begin
        if (!bus.fifo_full) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ERR_SEND;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // strobes and data outputs
  always_comb begin
    bus.alu_en     = 1'b0;
    bus.alu_func   = '0;
    bus.alu_clk_en = 1'b0;
    bus.addr       = '0;
    bus.wr_en      = 1'b0;
    bus.rd_en      = 1'b0;
    bus.wr_data    = '0;
    bus.tx_data    = '0;
    bus.tx_push    = 1'b0;
    bus.frame_err  = timer_hit_s;
    case (state_r)
      ST_IDLE: begin
        if (bus.rx_valid) begin
          case (bus.rx_data)
            DATA_W'(CMD_WR), DATA_W'(CMD_RD), DATA_W'(CMD_BURST),
            DATA_W'(CMD_ALU), DATA_W'(CMD_ALU_NOP): bus.frame_err = 1'b0;
            default:                                 bus.frame_err = 1'b1;
          endcase
        end else begin
          bus.frame_err = 1'b0;
        end
      end
      ST_WR_DATA: begin
        if (bus.rx_valid) begin
          bus.wr_en   = 1'b1;
          bus.addr    = addr_r;
          bus.wr_data = bus.rx_data;
        end else begin
          bus.wr_en = 1'b0;
        end
      end
      ST_RD_CNT: begin
        if (bus.rx_valid && (bus.rx_data == '0)) begin
          bus.frame_err = 1'b1;
        end else begin
          bus.frame_err = timer_hit_s;
        end
      end
      ST_RD_REQ: begin
        bus.rd_en = 1'b1;
        bus.addr  = addr_r;
      end
      ST_RD_SEND: begin
        bus.tx_data = tx_r;
        bus.tx_push = !bus.fifo_full;
      end
      ST_OPA, ST_OPB: begin
        bus.alu_clk_en = 1'b1;
        if (bus.rx_valid) begin
          bus.wr_en   = 1'b1;
          bus.addr    = (state_r == ST_OPA) ? OPA_ADDR : OPB_ADDR;
          bus.wr_data = bus.rx_data;
        end else begin
          bus.wr_en = 1'b0;
        end
      end
      ST_FUNC: bus.alu_clk_en = 1'b1;
      ST_ALU_RUN: begin
        bus.alu_clk_en = 1'b1;
        bus.alu_en     = 1'b1;
        bus.alu_func   = func_r;
      end
      ST_ALU_SEND: begin
        bus.alu_clk_en = 1'b1;
        bus.tx_data    = res_shift_s[DATA_W-1:0];
        bus.tx_push    = !bus.fifo_full;
      end
      ST_ERR_SEND: begin
        bus.tx_data = ERR_CODE;
        bus.tx_push = !bus.fifo_full;
      end
      default: bus.frame_err = timer_hit_s;
    endcase
  end

endmodule

// File: tb/tb_sys_ctrl_frame.sv
// Directed bench for sys_ctrl_frame: framed commands with hand-computed
// register, ALU and TX FIFO traffic.
module tb_sys_ctrl_frame;
  import sys_ctrl_pkg::*;

  localparam int DATA_W    = 8;
  localparam int ADDR_W    = 4;
  localparam int FUNC_W    = 4;
  localparam int ALU_OUT_W = 32;
  localparam int TIMEOUT   = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sys_ctrl_frame_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUNC_W(FUNC_W),
                      .ALU_OUT_W(ALU_OUT_W)) bus ();

  sys_ctrl_frame #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FUNC_W(FUNC_W), .ALU_OUT_W(ALU_OUT_W),
    .TIMEOUT(TIMEOUT), .OPA_ADDR(4'h0), .OPB_ADDR(4'h1), .ERR_CODE(8'hFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // register-file model: address 5 holds 3C, every other address reads A<addr>
  always_comb bus.rd_data = (bus.addr == 4'h5) ? 8'h3C : {4'hA, bus.addr};

  logic [7:0]  push_q[$];
  logic [3:0]  rd_q[$];
  logic [11:0] wr_q[$];
  int          err_n = 0;
  int          full_push_n = 0;
  logic [3:0]  last_func = 4'h0;
  int          n_pass = 0;
  int          n_total = 0;
  int          snap;

  // traffic monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.tx_push) begin
      push_q.push_back(bus.tx_data);
      if (bus.fifo_full) full_push_n++;
    end
    if (bus.rd_en) rd_q.push_back(bus.addr);
    if (bus.wr_en) wr_q.push_back({bus.addr, bus.wr_data});
    if (bus.frame_err) err_n++;
    if (bus.alu_en) last_func = bus.alu_func;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clear_logs;
    push_q.delete(); rd_q.delete(); wr_q.delete(); err_n = 0;
  endtask

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.alu_out = 32'hA1B2C3D4;
    bus.alu_valid = 1'b1; bus.rd_valid = 1'b1; bus.fifo_full = 1'b0;
    idle(3);
    check("rst_alu_en", 32'(bus.alu_en), 32'h0);
    check("rst_tx_push", 32'(bus.tx_push), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en), 32'h0);
    check("rst_rd_en", 32'(bus.rd_en), 32'h0);
    check("rst_clk_div_en", 32'(bus.clk_div_en), 32'h1);
    check("rst_alu_clk_en", 32'(bus.alu_clk_en), 32'h0);
    rst = 1'b1;
    idle(1);

    clear_logs();
    send(8'hAA); send(8'h05); send(8'h3C); idle(3);
    check("wr_count", 32'(wr_q.size()), 32'd1);
    check("wr_addr_data", 32'(wr_q[0]), 32'h53C);
    check("wr_no_push", 32'(push_q.size()), 32'd0);

    clear_logs();
    send(8'hBB); send(8'h05); idle(5);
    check("rd_count", 32'(rd_q.size()), 32'd1);
    check("rd_addr", 32'(rd_q[0]), 32'h5);
    check("rd_push_count", 32'(push_q.size()), 32'd1);
    check("rd_push_data", 32'(push_q[0]), 32'h3C);

    clear_logs();
    send(8'hEE); send(8'h0E); send(8'h03); idle(10);
    check("burst_rd_count", 32'(rd_q.size()), 32'd3);
    check("burst_rd_addr0", 32'(rd_q[0]), 32'hE);
    check("burst_rd_addr1", 32'(rd_q[1]), 32'hF);
    check("burst_rd_addr2", 32'(rd_q[2]), 32'h0);
    check("burst_push_count", 32'(push_q.size()), 32'd3);
    check("burst_push0", 32'(push_q[0]), 32'hAE);
    check("burst_push1", 32'(push_q[1]), 32'hAF);
    check("burst_push2", 32'(push_q[2]), 32'hA0);

    clear_logs();
    send(8'hEE); send(8'h05); send(8'h00); idle(4);
    check("cnt0_err", 32'(err_n), 32'd1);
    check("cnt0_push_count", 32'(push_q.size()), 32'd1);
    check("cnt0_push", 32'(push_q[0]), 32'hFF);
    check("cnt0_no_rd", 32'(rd_q.size()), 32'd0);

    clear_logs();
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    idle(3);
    bus.fifo_full = 1'b1;
    idle(10);
    check("alu_stall_push_count", 32'(push_q.size()), 32'd2);
    bus.fifo_full = 1'b0;
    idle(4);
    check("alu_wr_count", 32'(wr_q.size()), 32'd2);
    check("alu_wr_opa", 32'(wr_q[0]), 32'h012);
    check("alu_wr_opb", 32'(wr_q[1]), 32'h134);
    check("alu_func", 32'(last_func), 32'h1);
    check("alu_push_count", 32'(push_q.size()), 32'd4);
    check("alu_push0", 32'(push_q[0]), 32'hD4);
    check("alu_push1", 32'(push_q[1]), 32'hC3);
    check("alu_push2", 32'(push_q[2]), 32'hB2);
    check("alu_push3", 32'(push_q[3]), 32'hA1);

    clear_logs();
    send(8'h42); idle(3);
    check("unk_err", 32'(err_n), 32'd1);
    check("unk_push_count", 32'(push_q.size()), 32'd1);
    check("unk_push", 32'(push_q[0]), 32'hFF);

    clear_logs();
    send(8'hAA); idle(15);
    check("tmo_early_err", 32'(err_n), 32'd0);
    idle(15);
    check("tmo_err", 32'(err_n), 32'd1);
    check("tmo_no_wr", 32'(wr_q.size()), 32'd0);
    check("tmo_no_push", 32'(push_q.size()), 32'd0);
    send(8'hBB); send(8'h07); idle(5);
    check("tmo_recover_push", 32'(push_q.size()), 32'd1);
    check("tmo_recover_data", 32'(push_q[0]), 32'hA7);

    clear_logs();
    send(8'hEE); send(8'h00); send(8'h08); idle(3);
    rst = 1'b0;
    #1;
    check("midrst_tx_push", 32'(bus.tx_push), 32'h0);
    check("midrst_rd_en", 32'(bus.rd_en), 32'h0);
    check("midrst_addr", 32'(bus.addr), 32'h0);
    check("midrst_clk_div_en", 32'(bus.clk_div_en), 32'h1);
    snap = push_q.size();
    idle(3);
    check("midrst_no_push", 32'(push_q.size()), 32'(snap));
    rst = 1'b1;
    idle(1);
    clear_logs();
    send(8'hAA); send(8'h07); send(8'h55); idle(3);
    check("postrst_wr_count", 32'(wr_q.size()), 32'd1);
    check("postrst_wr", 32'(wr_q[0]), 32'h755);
    check("postrst_no_push", 32'(push_q.size()), 32'd0);
    check("never_push_when_full", 32'(full_push_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sys_ctrl_frame.md
# sys_ctrl_frame

Parametrised command-frame controller between the UART RX byte stream and the register file, ALU and TX FIFO. It decodes framed commands: register write, single read, burst read, ALU with operands, and ALU without operands. It drives register-file and ALU strobes and pushes results to the TX FIFO as DATA_W-wide bytes. Compared with the previous controller it adds burst read, a configurable ALU result width, an inter-byte timeout, and an error byte for unknown commands.

## Interface
- DATA_W, 8, RX/TX/register data width
- ADDR_W, 4, register-file address width
- FUNC_W, 4, ALU function width (low FUNC_W bits of the function byte)
- ALU_OUT_W, 16, ALU result width; must be a multiple of DATA_W
- TIMEOUT, 1023, inter-byte timeout in clk cycles; 0 disables
- OPA_ADDR, 0 / OPB_ADDR, 1, operand register addresses
- ERR_CODE, 8'hFF, byte pushed on an unknown command
- clk  in  1  system clock
- rst  in  1  reset; rst asynchronous, active-low; clock clk
- rx_data  in  DATA_W  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- alu_out  in  ALU_OUT_W  ALU result
- alu_valid  in  1  ALU result valid
- rd_data  in  DATA_W  register-file read data
- rd_valid  in  1  read data valid
- fifo_full  in  1  TX FIFO full
- alu_en  out  1  ALU operate enable
- alu_func  out  FUNC_W  ALU function
- alu_clk_en  out  1  ALU clock-gate enable
- addr  out  ADDR_W  register-file address
- wr_en / rd_en  out  1  register-file strobes
- wr_data  out  DATA_W  register write data
- tx_data  out  DATA_W  byte to TX FIFO
- tx_push  out  1  TX FIFO write strobe
- clk_div_en  out  1  clock-divider enable; constant 1
- frame_err  out  1  one-cycle pulse on an unknown command or timeout

## Operation
- Commands (first byte): AA = write (addr, data); BB = read (addr); EE = burst read (addr, count); CC = ALU (opA, opB, func); DD = ALU no-operand (func).
- Address bytes use the low ADDR_W bits.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, RD_REQ, RD_SEND, OPA, OPB, FUNC, ALU_RUN, ALU_SEND, ERR_SEND.
- IDLE: the command is decoded in the same cycle as rx_valid. An unknown byte pulses frame_err and goes to ERR_SEND.
- WR_ADDR: on rx_valid, latch addr_reg.
- WR_DATA: on rx_valid, assert wr_en=1 with addr=addr_reg and wr_data=rx_data in that same cycle, then go to IDLE.
- RD_ADDR: latch addr_reg. BB sets cnt=1 and goes to RD_REQ. EE goes to RD_CNT.
- RD_CNT: latch cnt=rx_data. A count of 0 pulses frame_err and goes to ERR_SEND.
- RD_REQ: rd_en=1, addr=addr_reg until rd_valid. On rd_valid, latch rd_data into tx_reg.
- RD_SEND: tx_data=tx_reg; tx_push=1 when !fifo_full. Then decrement cnt and increment addr_reg modulo 2^ADDR_W (wraps). Go to RD_REQ if cnt is nonzero, else IDLE.
- OPA: on rx_valid, wr_en=1, addr=OPA_ADDR, wr_data=rx_data.
- OPB: same as OPA with addr=OPB_ADDR.
- FUNC: on rx_valid, latch func_reg.
- ALU_RUN: alu_en=1, alu_func=func_reg until alu_valid. On alu_valid, latch alu_out and clear byte index.
- ALU_SEND: push ALU_OUT_W/DATA_W bytes, LSB first, one per cycle while !fifo_full. Stall (no push, hold index) while full. After the last byte, go to IDLE.
- ERR_SEND: push ERR_CODE when !fifo_full, then go to IDLE.
- alu_clk_en=1 in OPA, OPB, FUNC, ALU_RUN, ALU_SEND.
- All other outputs are 0 unless stated; clk_div_en is constant 1.

## Timing
- Reset value of every output: 0, except clk_div_en=1.
- Reset clears the state (to IDLE), addr_reg, cnt, func_reg, tx_reg, the result register and the timer. Reset asserted mid-frame aborts the frame with no push.
- Strobes (wr_en, rd_en, tx_push) are combinational from state, registered context and inputs. Each is asserted for exactly one cycle per byte or transfer.
- Write latency: wr_en is asserted in the cycle the final frame byte arrives.
- TX pushes are at most one per cycle, and never while fifo_full=1.
- Timeout: the timer clears on every rx_valid and counts only in WR_ADDR, WR_DATA, RD_ADDR, RD_CNT, OPA, OPB, FUNC.
- When the timer reaches TIMEOUT: pulse frame_err, go to IDLE, no push.
- rx_valid in the same cycle the timer reaches TIMEOUT: the byte wins and the timer clears.
- rx_valid during RD_REQ, RD_SEND, ALU_RUN, ALU_SEND or ERR_SEND: the byte is dropped.

## Structure
- Package sys_ctrl_pkg holds the command opcodes (AA, BB, CC, DD, EE), the state enumeration and the default ERR_CODE.
- Sub-module frame_timer: inter-byte timeout counter with clear, enable and TIMEOUT parameter; outputs a hit pulse.
- Everything else stays in one FSM module.

## Test plan
- Frame AA,05,3C -> one wr_en cycle with addr=5, wr_data=3C; no push.
- BB,05 with rd_data=3C -> one rd_en phase, one push of 3C.
- EE,0E,03 -> reads addresses E, F, 0 (wrap) and pushes 3 bytes in order.
- EE with count byte 0 -> frame_err pulse, one push of FF.
- CC,12,34,01 with ALU_OUT_W=32 and alu_out=A1B2C3D4 -> wr to addr 0 (12), wr to addr 1 (34), alu_func=1, then pushes D4, C3, B2, A1.
- fifo_full held high 10 cycles mid ALU_SEND -> no push and no skipped byte.
- Unknown byte 42 -> frame_err, push FF.
- AA then silence for TIMEOUT cycles -> frame_err, return to IDLE, no wr_en.
- rst low mid-EE burst -> all outputs at reset values; the next frame decodes normally.
